// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down counter.
package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_counter.sv
// Loadable, cascadable down counter with terminal-count pulse.
// Define DOWN_COUNTER_AUTORELOAD_EN for periodic (auto-reload) mode; default is one-shot.
//
// state | meaning
// IDLE  | after clear; count ignored, a_count holds
// RUN   | decrementing on count
// DONE  | one-shot expired; a_count holds 0 until load or clear
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             count,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] a_count,
  output logic             b_out,
  output logic             tc_pulse,
  output logic             busy
);

  state_t state;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  // Combinational so a cascaded stage sees the borrow in the same cycle.
  assign b_out = ~|a_count;

  always_ff @(posedge clk) begin
    if (clear) begin
      a_count  <= '0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      reload   <= '0;
`endif
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
      state    <= IDLE;
    end else begin
      tc_pulse <= 1'b0;
      if (load) begin
        a_count <= din;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload  <= din;
`endif
        state   <= RUN;
        busy    <= 1'b1;
      end else if (state == RUN && count) begin
        if (a_count == '0) begin
          tc_pulse <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
          a_count  <= reload;
`else
          state    <= DONE;
          busy     <= 1'b0;
`endif
        end else begin
          a_count <= a_count - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench: directed test-plan steps, then random stimulus on a
// two-stage cascade checked every cycle against a behavioural model.
module tb_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         lo_clear, lo_load, lo_count;
  logic [W-1:0] lo_din;
  logic [W-1:0] lo_a;
  logic         lo_b, lo_tc, lo_busy;

  logic         hi_clear, hi_load;
  logic [W-1:0] hi_din;
  logic [W-1:0] hi_a;
  logic         hi_b, hi_tc, hi_busy;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  down_counter #(.WIDTH(W)) u_lo (
    .clk(clk), .clear(lo_clear), .load(lo_load), .count(lo_count), .din(lo_din),
    .a_count(lo_a), .b_out(lo_b), .tc_pulse(lo_tc), .busy(lo_busy)
  );

  down_counter #(.WIDTH(W)) u_hi (
    .clk(clk), .clear(hi_clear), .load(hi_load), .count(lo_b), .din(hi_din),
    .a_count(hi_a), .b_out(hi_b), .tc_pulse(hi_tc), .busy(hi_busy)
  );

  // Behavioural model: mode 0 = idle, 1 = running, 2 = expired.
  typedef struct {
    int value;
    int reload;
    int mode;
    bit tc;
  } model_t;

  model_t lo_m, hi_m;

  function automatic model_t step(model_t s, bit clr, bit ld, bit cn, int d);
    model_t n = s;
    n.tc = 1'b0;
    if (clr) begin
      n.value = 0; n.reload = 0; n.mode = 0;
    end else if (ld) begin
      n.value = d; n.reload = d; n.mode = 1;
    end else if (s.mode == 1 && cn) begin
      if (s.value == 0) begin
        n.tc = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        n.value = s.reload;
`else
        n.mode = 2;
`endif
      end else begin
        n.value = s.value - 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    hi_m = step(hi_m, hi_clear, hi_load, (lo_m.value == 0), int'(hi_din));
    lo_m = step(lo_m, lo_clear, lo_load, lo_count, int'(lo_din));
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("lo_a_count", int'(lo_a), lo_m.value);
      check("lo_b_out",   int'(lo_b), int'(lo_m.value == 0));
      check("lo_tc",      int'(lo_tc), int'(lo_m.tc));
      check("lo_busy",    int'(lo_busy), int'(lo_m.mode == 1));
      check("hi_a_count", int'(hi_a), hi_m.value);
      check("hi_b_out",   int'(hi_b), int'(hi_m.value == 0));
      check("hi_tc",      int'(hi_tc), int'(hi_m.tc));
      check("hi_busy",    int'(hi_busy), int'(hi_m.mode == 1));
    end
  end

  task automatic cyc(input bit clr, input bit ld, input bit cn, input int d);
    lo_clear = clr; lo_load = ld; lo_count = cn; lo_din = W'(d);
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input int a, input int b, input int tc, input int bz);
    check({name, "_a"},    int'(lo_a), a);
    check({name, "_b"},    int'(lo_b), int'(a == 0));
    check({name, "_tc"},   int'(lo_tc), tc);
    check({name, "_busy"}, int'(lo_busy), bz);
    check({name, "_mdl"},  lo_m.value, a);
  endtask

  initial begin
    hi_clear = 1'b1; hi_load = 1'b0; hi_din = '0;
    lo_clear = 1'b1; lo_load = 1'b0; lo_count = 1'b0; lo_din = '0;
    #2;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    hi_clear = 1'b0;
    chk_en = 1'b1;
    cyc(0, 0, 0, 0);
    lit("reset", 0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    lit("idle_count", 0, 1, 0, 0);

    cyc(0, 1, 0, 3);
    lit("load3", 3, 0, 0, 1);
    cyc(0, 0, 1, 0); lit("cnt1", 2, 0, 0, 1);
    cyc(0, 0, 1, 0); lit("cnt2", 1, 0, 0, 1);
    cyc(0, 0, 1, 0); lit("cnt3", 0, 1, 0, 1);
    cyc(0, 0, 1, 0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
    lit("under", 3, 0, 1, 1);
    cyc(0, 0, 1, 0); lit("after", 2, 0, 0, 1);
`else
    lit("under", 0, 1, 1, 0);
    cyc(0, 0, 1, 0); lit("after", 0, 1, 0, 0);
`endif

    cyc(0, 1, 1, 9);
    lit("load_wins", 9, 0, 0, 1);
    repeat (4) cyc(0, 0, 1, 0);
    lit("at5", 5, 0, 0, 1);
    cyc(1, 0, 1, 0);
    lit("abort", 0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    lit("abort_idle", 0, 1, 0, 0);

    cyc(0, 1, 0, 0);
    lit("load0", 0, 1, 0, 1);
    cyc(0, 0, 1, 0);
    check("din0_tc", int'(lo_tc), 1);

    cyc(0, 1, 0, 2);
    cyc(0, 0, 1, 0); lit("tog1", 1, 0, 0, 1);
    cyc(0, 0, 0, 0); lit("tog0a", 1, 0, 0, 1);
    cyc(0, 0, 1, 0); lit("tog2", 0, 1, 0, 1);
    cyc(0, 0, 0, 0); check("tog0b_tc", int'(lo_tc), 0);
    cyc(0, 0, 1, 0); check("tog3_tc", int'(lo_tc), 1);

    for (int i = 0; i < 2000; i++) begin
      hi_clear = ($urandom_range(0, 99) < 2);
      hi_load  = ($urandom_range(0, 99) < 4);
      hi_din   = W'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 70),
          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)));
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
- Loadable, cascadable binary down counter with a terminal-count pulse. It is the counting-down counterpart of the team's 4-bit universal up counter.
- Used as a one-shot delay or a periodic tick generator; the zero flag chains borrow into a higher stage.
- Small control FSM tracks idle, running and expired conditions.

Parameters:
- WIDTH, 4, counter width in bits (min 2).

Ports:
- clk  input  1  rising-edge clock
- clear  input  1  synchronous, active-high reset
- load  input  1  load din into counter and reload register; priority over count
- count  input  1  decrement enable
- din  input  WIDTH  load value
- a_count  output  WIDTH  current count, registered
- b_out  output  1  borrow/zero flag, combinational ~|a_count, for cascading into next stage's count
- tc_pulse  output  1  registered one-cycle pulse on underflow event
- busy  output  1  registered, high while FSM in RUN

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port clear.
- Reset (clear=1 at posedge):
  - a_count=0, reload register=0, tc_pulse=0, busy=0, state=IDLE.
  - clear overrides load and count.
  - Mid-count reset aborts with no tc_pulse.
- States:
  - IDLE: count ignored; a_count holds.
  - RUN: counting.
  - DONE: expired; a_count holds 0; count ignored.
- Transitions:
  - Any state, load=1: a_count<=din, reload<=din, state<=RUN, tc_pulse<=0. load wins over a simultaneous count.
  - RUN, count=1, a_count>0: a_count<=a_count-1 (modulo 2^WIDTH not reached).
  - RUN, count=1, a_count==0: underflow event, tc_pulse<=1 next cycle. Next state per Optional Feature.
  - RUN, count=0: hold.
- tc_pulse:
  - High exactly one cycle per underflow event.
  - Cleared the following cycle unless another underflow occurs.
- Period: din=N gives an underflow on the (N+1)th count-enabled cycle. din=0 underflows on the first count.
- b_out reflects a_count==0 in all states, including IDLE after reset (b_out=1).
- busy mirrors state==RUN, updated with state (one cycle after the load edge it is visible with the loaded value).
- No latency between a count edge and the updated a_count beyond one register stage.

Optional Feature:
- Macro: DOWN_COUNTER_AUTORELOAD_EN.
- Defined (periodic mode):
  - On underflow, a_count<=reload register and state stays RUN.
  - tc_pulse repeats every N+1 count cycles.
  - If load coincides with underflow, load wins and no tc_pulse is issued.
- Undefined (one-shot mode):
  - On underflow, state<=DONE, a_count stays 0, busy<=0.
  - Only load or clear leave DONE.

Decomposition:
- Package down_counter_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding 00/01/10
  - DEFAULT_WIDTH=4 constant
- No sub-module: FSM and datapath live in one module.
- Cascading is done at top level by wiring b_out of stage k to the count of stage k+1.

Test Plan:
- clear=1 for 2 cycles, then 0 -> a_count=0, b_out=1, busy=0, tc_pulse=0. count=1 in IDLE leaves a_count=0 with no pulse.
- load din=3, then count=1 for 5 cycles:
  - a_count 3,2,1,0, underflow on 4th count -> tc_pulse=1 for one cycle.
  - One-shot: state DONE, busy=0, a_count stays 0.
  - AUTORELOAD_EN: a_count=3 after underflow, next pulse 4 counts later.
- load=1 and count=1 same cycle with din=9 (WIDTH=4) -> a_count=9, no decrement, busy=1.
- RUN at a_count=5, clear=1 with count=1 -> a_count=0, IDLE, tc_pulse stays 0.
- load din=0, count=1 -> tc_pulse on first count. Toggle count 1/0 alternately with din=2 -> underflow only after 3 enabled cycles.
- Two WIDTH=4 instances cascaded (b_out of low drives count of high, low in AUTORELOAD_EN) -> high stage decrements once per low-stage zero cycle.
